// File: rtl/controlador_display.sv
// controlador_display
// Time-multiplexed scan controller for the vending machine's multi-digit
// 7-segment display. One 4-bit symbol code is stored per digit. The single
// shared decoder is driven for one digit slot at a time. The block provides a
// blanking gap at the start of each slot, per-digit blink and a write port.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_valid     write request (held by the writer until accepted)
//   wr_ready     controller can accept a write (drops for one cycle after a transfer)
//   wr_idx       target digit position
//   wr_code      symbol code to store
//   wr_err       one-cycle pulse after an accepted write with wr_idx >= N_DIGITS
//   blink_mask   bit i = 1 makes digit i blink
//   dec_code     code for the shared decoder (4'b1111 = all segments off)
//   dig_en       one-hot active-high digit enable, all zero while dark
//   frame_start  one-cycle pulse in the first cycle of slot 0
module controlador_display #(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK        = 8,
    parameter int BLINK_FRAMES = 64,
    localparam int IDX_W       = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3:0]          wr_code,
    output logic                wr_err,
    input  logic [N_DIGITS-1:0] blink_mask,
    output logic [3:0]          dec_code,
    output logic [N_DIGITS-1:0] dig_en,
    output logic                frame_start
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W:0] NDIG_C = (IDX_W+1)'(N_DIGITS);
    localparam logic [3:0] CODE_OFF = 4'b1111;

    // ST_START is only held during reset; the first edge after release
    // moves into slot 0 / cnt 0, so that cycle already shows frame_start.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_slot;
    logic [FR_W-1:0]      r_frame;
    logic                 r_phase;
    logic [3:0]           r_code [N_DIGITS];
    logic [3:0]           r_hold_code;
    logic                 r_hold_mask;
    logic                 r_wr_ready;
    logic                 r_wr_err;
    logic [3:0]           r_dec_code;
    logic [N_DIGITS-1:0]  r_dig_en;
    logic                 r_frame_start;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_slot_nxt;
    logic [FR_W-1:0]      w_frame_nxt;
    logic                 w_phase_nxt;
    logic                 w_show_entry;
    logic [3:0]           w_code_cur;
    logic                 w_mask_cur;
    logic [3:0]           w_hold_code_nxt;
    logic                 w_hold_mask_nxt;
    logic [3:0]           w_dec_nxt;
    logic [N_DIGITS-1:0]  w_dig_en_nxt;
    logic                 w_frame_start_nxt;
    logic                 w_accept;
    logic                 w_idx_bad;

    assign w_accept  = wr_valid & r_wr_ready;
    assign w_idx_bad = ({1'b0, wr_idx} >= NDIG_C);

    // Next scan position (cnt, slot, frame, blink phase) and slot sub-state.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_slot_nxt  = r_slot;
        w_frame_nxt = r_frame;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_BLANK, ST_SHOW: begin
                if (r_cnt == CNT_W'(PRESCALE-1)) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    if (r_slot == IDX_W'(N_DIGITS-1)) begin
                        w_slot_nxt = {IDX_W{1'b0}};
                        // Phase flips on the frame wrap, i.e. on a slot boundary.
                        if (r_frame == FR_W'(BLINK_FRAMES-1)) begin
                            w_frame_nxt = {FR_W{1'b0}};
                            w_phase_nxt = ~r_phase;
                        end else begin
                            w_frame_nxt = r_frame + FR_W'(1);
                        end
                    end else begin
                        w_slot_nxt = r_slot + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt  = {CNT_W{1'b0}};
                w_slot_nxt = {IDX_W{1'b0}};
            end
        endcase

        if (w_cnt_nxt < CNT_W'(BLANK)) begin
            w_state_nxt = ST_BLANK;
        end else begin
            w_state_nxt = ST_SHOW;
        end
        w_show_entry = (w_cnt_nxt == CNT_W'(BLANK));
    end

    // Display outputs for the upcoming cycle; code and mask are latched on SHOW entry.
    always_comb begin
        w_code_cur   = CODE_OFF;
        w_mask_cur   = 1'b0;
        w_dig_en_nxt = {N_DIGITS{1'b0}};
        w_dec_nxt    = CODE_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_code_cur = (w_slot_nxt == IDX_W'(i)) ? r_code[i] : w_code_cur;
            w_mask_cur = (w_slot_nxt == IDX_W'(i)) ? blink_mask[i] : w_mask_cur;
        end
        // r_code is read before this edge's write lands, so a write on the
        // entry edge is seen only in the next frame.
        w_hold_code_nxt = w_show_entry ? w_code_cur : r_hold_code;
        w_hold_mask_nxt = w_show_entry ? w_mask_cur : r_hold_mask;

        case (w_state_nxt)
            ST_SHOW: begin
                if (w_phase_nxt && w_hold_mask_nxt) begin
                    w_dig_en_nxt = {N_DIGITS{1'b0}};
                    w_dec_nxt    = CODE_OFF;
                end else begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        w_dig_en_nxt[i] = (w_slot_nxt == IDX_W'(i));
                    end
                    w_dec_nxt = w_hold_code_nxt;
                end
            end
            default: begin
                w_dig_en_nxt = {N_DIGITS{1'b0}};
                w_dec_nxt    = CODE_OFF;
            end
        endcase

        w_frame_start_nxt = (w_slot_nxt == {IDX_W{1'b0}}) && (w_cnt_nxt == {CNT_W{1'b0}});
    end

    // Scan state, handshake and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_START;
            r_cnt         <= {CNT_W{1'b0}};
            r_slot        <= {IDX_W{1'b0}};
            r_frame       <= {FR_W{1'b0}};
            r_phase       <= 1'b0;
            r_hold_code   <= CODE_OFF;
            r_hold_mask   <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_wr_err      <= 1'b0;
            r_dec_code    <= CODE_OFF;
            r_dig_en      <= {N_DIGITS{1'b0}};
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_slot        <= w_slot_nxt;
            r_frame       <= w_frame_nxt;
            r_phase       <= w_phase_nxt;
            r_hold_code   <= w_hold_code_nxt;
            r_hold_mask   <= w_hold_mask_nxt;
            // Ready drops for exactly one cycle after every transfer.
            r_wr_ready    <= ~w_accept;
            r_wr_err      <= w_accept & w_idx_bad;
            r_dec_code    <= w_dec_nxt;
            r_dig_en      <= w_dig_en_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Per-digit code storage; out-of-range indices match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_code[i] <= CODE_OFF;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (w_accept && !w_idx_bad && (wr_idx == IDX_W'(i))) begin
                    r_code[i] <= wr_code;
                end else begin
                    r_code[i] <= r_code[i];
                end
            end
        end
    end

    assign wr_ready    = r_wr_ready;
    assign wr_err      = r_wr_err;
    assign dec_code    = r_dec_code;
    assign dig_en      = r_dig_en;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_controlador_display.sv
// Testbench for controlador_display: a 4-digit instance carries the main
// scenarios and a 3-digit instance exercises the out-of-range write index.
// Expected cycles are queued at each rising edge and checked at the falling edge.
module tb_controlador_display;
    localparam int P  = 10;
    localparam int B  = 2;
    localparam int N  = 4;
    localparam int BF = 2;
    localparam int N3 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_ready, wr_err, frame_start;
    logic [1:0] wr_idx;
    logic [3:0] wr_code, blink_mask, dec_code, dig_en;

    logic       wr3_valid, wr3_ready, wr3_err, fs3;
    logic [1:0] wr3_idx;
    logic [3:0] wr3_code, dec3;
    logic [2:0] blink3, dig3;

    controlador_display #(.N_DIGITS(N), .PRESCALE(P), .BLANK(B), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_code(wr_code), .wr_err(wr_err), .blink_mask(blink_mask),
        .dec_code(dec_code), .dig_en(dig_en), .frame_start(frame_start));

    controlador_display #(.N_DIGITS(N3), .PRESCALE(P), .BLANK(B), .BLINK_FRAMES(BF)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr3_valid), .wr_ready(wr3_ready),
        .wr_idx(wr3_idx), .wr_code(wr3_code), .wr_err(wr3_err), .blink_mask(blink3),
        .dec_code(dec3), .dig_en(dig3), .frame_start(fs3));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] dec;
        logic       fs;
        logic       rdy;
        logic       err;
    } exp_t;

    localparam exp_t RST_EXP = '{en: 4'b0000, dec: 4'hF, fs: 1'b0, rdy: 1'b0, err: 1'b0};

    exp_t q[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (time-indexed since reset release).
    bit         m_started = 1'b0;
    int         m_t = 0, m_cnt = 0, m_slot = 0;
    logic       m_phase = 1'b0, m_ready = 1'b0, m_hmask = 1'b0;
    logic [3:0] m_hold = 4'hF;
    logic [3:0] m_code [N] = '{default: 4'hF};
    int         m3_t = 0;
    bit         m3_started = 1'b0;
    logic       m3_ready = 1'b0;

    task automatic chk(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got en=%b dec=%h fs=%b rdy=%b err=%b, want en=%b dec=%h fs=%b rdy=%b err=%b",
                     name, $time, got.en, got.dec, got.fs, got.rdy, got.err,
                     want.en, want.dec, want.fs, want.rdy, want.err);
        end
    endtask

    // Expectation generator: one entry per cycle for each DUT.
    initial begin
        exp_t e, e3;
        logic acc, acc3;
        int   c3, s3;
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                m_started = 1'b0; m_t = 0; m_ready = 1'b0; m_hold = 4'hF; m_hmask = 1'b0;
                for (int i = 0; i < N; i++) m_code[i] = 4'hF;
                m3_started = 1'b0; m3_t = 0; m3_ready = 1'b0;
                q.delete(); q3.delete();
            end else begin
                acc = wr_valid && m_ready;
                if (!m_started) begin m_started = 1'b1; m_t = 0; end else m_t++;
                m_cnt   = m_t % P;
                m_slot  = (m_t / P) % N;
                m_phase = (((m_t / (P * N)) / BF) % 2) == 1;
                if (m_cnt == B) begin m_hold = m_code[m_slot]; m_hmask = blink_mask[m_slot]; end
                e.fs = (m_t % (P * N)) == 0;
                if (m_cnt < B || (m_phase && m_hmask)) begin
                    e.en = 4'b0000; e.dec = 4'hF;
                end else begin
                    e.en = 4'b0001 << m_slot; e.dec = m_hold;
                end
                e.rdy = !acc; e.err = 1'b0; m_ready = !acc;
                q.push_back(e);
                if (acc) m_code[wr_idx] = wr_code;

                acc3 = wr3_valid && m3_ready;
                if (!m3_started) begin m3_started = 1'b1; m3_t = 0; end else m3_t++;
                c3 = m3_t % P;
                s3 = (m3_t / P) % N3;
                e3.en  = (c3 < B) ? 4'b0000 : (4'b0001 << s3);
                e3.dec = 4'hF;
                e3.fs  = (m3_t % (P * N3)) == 0;
                e3.rdy = !acc3;
                e3.err = acc3 && (wr3_idx >= 2'd3);
                m3_ready = !acc3;
                q3.push_back(e3);
            end
        end
    end

    // Monitor: compares outputs at the falling edge.
    initial begin
        exp_t e, e3;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || q.size() == 0 || q3.size() == 0) begin
                chk("reset4", {dig_en, dec_code, frame_start, wr_ready, wr_err}, RST_EXP);
                chk("reset3", {1'b0, dig3, dec3, fs3, wr3_ready, wr3_err}, RST_EXP);
            end else begin
                e  = q.pop_front();
                e3 = q3.pop_front();
                chk("scan4", {dig_en, dec_code, frame_start, wr_ready, wr_err}, e);
                chk("scan3", {1'b0, dig3, dec3, fs3, wr3_ready, wr3_err}, e3);
            end
            checks++;
            if (!$onehot0(dig_en)) begin
                errors++;
                $display("FAIL onehot at %0t: got dig_en=%b, want at most one bit set", $time, dig_en);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [3:0] code, input int hold);
        wr_valid = 1'b1; wr_idx = idx; wr_code = code;
        repeat (hold) tick();
        wr_valid = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] idx, input logic [3:0] code, input int hold);
        wr3_valid = 1'b1; wr3_idx = idx; wr3_code = code;
        repeat (hold) tick();
        wr3_valid = 1'b0;
    endtask

    // Advance until the current cycle is (slot, cnt) of the 4-digit model.
    task automatic wait_pos(input int s, input int c);
        int n = 0;
        while (!(m_started && m_slot == s && m_cnt == c) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_pos: slot %0d cnt %0d not reached within 200 cycles", s, c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_idx = 2'd0; wr_code = 4'h0; blink_mask = 4'b0000;
        wr3_valid = 1'b0; wr3_idx = 2'd0; wr3_code = 4'h0; blink3 = 3'b000;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle scan: blank codes, frame_start every 40 cycles.
        repeat (80) tick();

        // Fill all digits; later writes are presented while ready is low.
        wr(2'd0, 4'h5, 1);
        wr(2'd1, 4'h6, 2);
        wr(2'd2, 4'h9, 2);
        wr(2'd3, 4'h8, 2);
        repeat (90) tick();

        // Write digit 2 during its own SHOW: shown value holds until next frame.
        wait_pos(2, 4);
        wr(2'd2, 4'h1, 1);
        repeat (80) tick();

        // Write digit 3 on its SHOW-entry edge: old value sampled this frame.
        wait_pos(3, 1);
        wr(2'd3, 4'hA, 1);
        repeat (80) tick();

        // Out-of-range index on the 3-digit instance.
        wr3(2'd3, 4'h4, 1);
        wr3(2'd3, 4'h2, 2);
        repeat (40) tick();

        // Blink digit 1 over four frames, then clear the mask mid-SHOW.
        wait_pos(3, 9);
        blink_mask = 4'b0010;
        repeat (160) tick();
        wait_pos(1, 5);
        blink_mask = 4'b0000;
        repeat (80) tick();

        // Reset mid-SHOW of slot 1 with a write request pending.
        wait_pos(1, 4);
        wr_valid = 1'b1; wr_idx = 2'd0; wr_code = 4'h3;
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (45) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/controlador_display.md
Name: controlador_display

Overview:
- Time-multiplexed scan controller for the vending machine's multi-digit 7-segment display.
- Holds one 4-bit symbol code per digit and drives the single shared symbol decoder, one digit slot at a time.
- Symbol codes: 0–5, E, 7, n, P and '.'. Code 4'b1111 decodes to all segments off.
- Provides a one-hot digit enable, inter-digit blanking against ghosting, per-digit blink, and a write handshake for the vending FSM.

Parameters:
- N_DIGITS, 4: number of digit positions (>=2). IDX_W = clog2(N_DIGITS).
- PRESCALE, 1000: clock cycles per digit slot (>=2).
- BLANK, 8: cycles at the start of each slot with all digits off (0 <= BLANK < PRESCALE).
- BLINK_FRAMES, 64: full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller can accept a write.
- wr_idx  in  IDX_W  target digit position.
- wr_code  in  4  symbol code for the decoder.
- wr_err  out  1  one-cycle pulse: accepted write had wr_idx >= N_DIGITS.
- blink_mask  in  N_DIGITS  bit i=1 makes digit i blink.
- dec_code  out  4  code to the shared decoder input E.
- dig_en  out  N_DIGITS  one-hot active-high digit enable; all zero when dark.
- frame_start  out  1  one-cycle pulse at the start of slot 0.

Behaviour:
- Reset values (while rst_n=0, asynchronous):
  - code registers: 4'b1111.
  - dec_code: 4'b1111.
  - dig_en: 0.
  - wr_ready, wr_err, frame_start: 0.
  - cnt, slot, frame_cnt: 0; blink phase: 0 (visible).
- After release: wr_ready=1 from the first clock edge. Scanning starts at slot 0, cnt 0.
- Counters:
  - cnt runs 0..PRESCALE-1, then wraps to 0.
  - On wrap, slot increments 0..N_DIGITS-1, then wraps to 0.
  - On slot wrap N_DIGITS-1 -> 0, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- All outputs are registered. The cycle where state is (slot=s, cnt=c) shows outputs for (s, c).
- Per-slot state machine:
  - BLANK (cnt < BLANK): dig_en=0, dec_code=4'b1111.
  - SHOW (cnt >= BLANK): on entry, code[s] and blink_mask[s] are sampled and held for the rest of the slot.
    - Visible: dig_en = 1<<s, dec_code = sampled code.
    - Hidden (phase=1 and sampled mask bit=1): dig_en=0, dec_code=4'b1111.
  - BLANK=0: the slot goes straight to SHOW, sampling at cnt 0.
- frame_start=1 exactly in the cycle with slot=0, cnt=0; 0 otherwise.
- Write handshake:
  - Transfer happens on a cycle with wr_valid & wr_ready.
  - wr_ready goes 0 in the following cycle and returns to 1 the cycle after. Maximum one write every 2 cycles.
  - A valid index updates code[wr_idx] at that edge.
  - An index >= N_DIGITS changes no register and pulses wr_err in the following cycle.
  - wr_valid while wr_ready=0 is ignored. The writer must hold it until accepted.
- Boundary conditions:
  - Write during SHOW of the same digit: the register updates, but displayed dec_code keeps the sampled value until that digit's next SHOW.
  - Write landing on the SHOW-entry edge of the same digit: the old value is sampled. The new value appears next frame.
  - blink_mask changes mid-SHOW have no effect until the next SHOW entry.
  - Phase toggle coincides with a slot boundary and applies from the new slot onward.
  - Reset mid-slot or mid-handshake: immediate return to reset values. All stored codes revert to 4'b1111 (display blank).
- Invariant: dig_en is never multi-hot in any cycle.

Test Plan (PRESCALE=10, BLANK=2, N_DIGITS=4, BLINK_FRAMES=2):
1. Reset then idle 80 cycles.
   - Expect: dig_en sequence per slot is 2 cycles 0000, then 8 cycles 0001/0010/0100/1000.
   - Expect: dec_code=4'b1111 throughout.
   - Expect: frame_start at cycles 0, 40, 80.
2. Write idx0=4'h5, idx1=4'h6, idx2=4'h9, idx3=4'h8.
   - Expect: each accepted with wr_ready dropping 1 cycle.
   - Expect next frame: SHOW values 5, 6, 9, 8 with matching one-hot dig_en.
3. During slot 2 SHOW (cnt=5), write idx2=4'h1.
   - Expect: dec_code stays 4'h9 to the slot end.
   - Expect: 4'h1 shown in slot 2 of the next frame.
4. Write wr_idx=3 with N_DIGITS=3 (separate build).
   - Expect: wr_err pulse 1 cycle after accept.
   - Expect: codes unchanged; wr_ready handshake identical.
5. blink_mask=4'b0010, run 4 frames.
   - Expect: slot 1 lit in frames 0-1, dark (dig_en=0, dec_code=4'b1111) in frames 2-3.
   - Expect: other slots always lit.
6. Assert rst_n=0 mid-SHOW of slot 1 with wr_valid held high.
   - Expect: dig_en=0, dec_code=4'b1111, wr_ready=0 immediately.
   - Expect after release: frame_start on the first cycle, blank display.
